// File: rtl/regfile_host_arbiter.sv
// Shares the register file write port and read port B between the core and the host debug interface.
// The core always wins; host accesses use idle slots, with a forced one-cycle core stall after MAX_WAIT denials.
module regfile_host_arbiter #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_write,
    input  logic [4:0]  core_wrAddr,
    input  logic [31:0] core_wrData,
    input  logic        core_rdB_valid,
    input  logic [4:0]  core_rdAddrB,
    output logic        core_stall,
    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic [1:0]  host_req_op,
    input  logic [4:0]  host_req_addr,
    input  logic [31:0] host_req_data,
    output logic        host_rsp_valid,
    input  logic        host_rsp_ready,
    output logic [31:0] host_rsp_data,
    output logic        host_rsp_err,
    output logic        rf_write,
    output logic [4:0]  rf_wrAddr,
    output logic [31:0] rf_wrData,
    output logic [4:0]  rf_rdAddrB,
    input  logic [31:0] rf_rdDataB
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [1:0]  OP_READ  = 2'b00;
    localparam logic [1:0]  OP_WRITE = 2'b01;
    localparam logic [1:0]  OP_CLEAR = 2'b10;
    localparam logic [4:0]  LAST_REG = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_CLEAR,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [4:0]         addr_q;
    logic [31:0]        data_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [4:0]         clr_q;
    logic               stall_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [31:0]        rsp_data_q;

    logic rd_free;
    logic wr_free;
    logic host_rd_slot;
    logic host_wr_slot;

    // Reset gates the host slots so an aborted clear issues no further writes.
    assign rd_free      = !core_rdB_valid && !reset;
    assign wr_free      = !core_write && !reset;
    assign host_rd_slot = (state_q == S_READ) && rd_free;
    assign host_wr_slot = ((state_q == S_WRITE) || (state_q == S_CLEAR)) && wr_free;

    assign core_stall     = stall_q;
    assign host_req_ready = (state_q == S_IDLE);
    assign host_rsp_valid = rsp_valid_q;
    assign host_rsp_data  = rsp_data_q;
    assign host_rsp_err   = rsp_err_q;

    always_comb begin
        rf_write   = core_write;
        rf_wrAddr  = core_wrAddr;
        rf_wrData  = core_wrData;
        rf_rdAddrB = core_rdAddrB;
        if (host_wr_slot) begin
            rf_write  = 1'b1;
            rf_wrAddr = (state_q == S_CLEAR) ? clr_q : addr_q;
            rf_wrData = (state_q == S_CLEAR) ? 32'd0 : data_q;
        end
        if (host_rd_slot) begin
            rf_rdAddrB = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 5'd0;
            data_q      <= 32'd0;
            wait_q      <= '0;
            clr_q       <= 5'd0;
            stall_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host_req_valid) begin
                        addr_q <= host_req_addr;
                        data_q <= host_req_data;
                        wait_q <= '0;
                        case (host_req_op)
                            OP_READ:  state_q <= S_READ;
                            OP_WRITE: state_q <= S_WRITE;
                            OP_CLEAR: begin
                                state_q <= S_CLEAR;
                                clr_q   <= 5'd1;
                                stall_q <= 1'b1;
                            end
                            default: begin
                                state_q     <= S_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b1;
                                rsp_data_q  <= 32'd0;
                            end
                        endcase
                    end
                end
                S_READ, S_WRITE: begin
                    if ((state_q == S_READ) ? rd_free : wr_free) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= (state_q == S_WRITE) ? data_q :
                                       (addr_q == 5'd0) ? 32'd0 : rf_rdDataB;
                        wait_q      <= '0;
                        stall_q     <= 1'b0;
                    end else begin
                        // Denied: count toward the forced stall, restarting if the core ignores it.
                        stall_q <= (wait_q == WAIT_W'(MAX_WAIT - 1));
                        wait_q  <= (wait_q == WAIT_W'(MAX_WAIT)) ? '0 : wait_q + WAIT_W'(1);
                    end
                end
                S_CLEAR: begin
                    if (wr_free) begin
                        if (clr_q == LAST_REG) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= 32'd31;
                            stall_q     <= 1'b0;
                        end else begin
                            clr_q <= clr_q + 5'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (host_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/regfile_host_arbiter.md
Name: regfile_host_arbiter

Overview:
- Shares the 32x32 register file's write port and read port B between the core pipeline and the host debug/terminal interface.
- The core always has priority; host reads and writes are slotted into idle cycles.
- Provides a host "clear-all" command that sequences zero-writes to x1..x31 while stalling the core.
- Sits between the core writeback/decode stages and the register file.

Parameters:
- MAX_WAIT, 16: consecutive cycles a pending host read/write may be denied before a one-cycle forced stall of the core.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- core_write  in  1  core write request
- core_wrAddr  in  5  core write address
- core_wrData  in  32  core write data
- core_rdB_valid  in  1  core is using read port B this cycle
- core_rdAddrB  in  5  core read port B address
- core_stall  out  1  core must hold: no write, no port-B use
- host_req_valid  in  1  host request valid
- host_req_ready  out  1  arbiter accepts request
- host_req_op  in  2  00 read, 01 write, 10 clear-all, 11 reserved
- host_req_addr  in  5  register index
- host_req_data  in  32  write data
- host_rsp_valid  out  1  response valid
- host_rsp_ready  in  1  host accepts response
- host_rsp_data  out  32  response data
- host_rsp_err  out  1  request rejected
- rf_write  out  1  to register file write enable
- rf_wrAddr  out  5  to register file write address
- rf_wrData  out  32  to register file write data
- rf_rdAddrB  out  5  to register file read port B address
- rf_rdDataB  in  32  from register file read port B data (core also consumes this directly)

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-high.
  - Reset values: state=IDLE, host_rsp_valid=0, host_rsp_err=0, host_rsp_data=0, core_stall=0, wait counter=0, clear counter=0.
  - Reset asserted mid-operation aborts it: no further host writes are issued and any pending response is dropped.
- Passthrough: whenever the arbiter is not taking a slot, rf_write/rf_wrAddr/rf_wrData/rf_rdAddrB equal core_write/core_wrAddr/core_wrData/core_rdAddrB combinationally.
- Core priority:
  - A write slot is free only when core_write=0.
  - A read slot is free only when core_rdB_valid=0.
  - Core requests win in every state, including while core_stall=1.
- States: IDLE, READ, WRITE, CLEAR, RESP.
- IDLE:
  - host_req_ready=1; the request is accepted on valid&ready, and op/addr/data are latched.
  - op 00 -> READ; op 01 -> WRITE; op 10 -> CLEAR with clear counter=1.
  - op 11 -> RESP with err=1, data=0.
- READ:
  - In the first free read cycle: rf_rdAddrB=latched addr, rf_rdDataB is captured into host_rsp_data, then -> RESP.
  - Addr 0 returns 0.
- WRITE:
  - In the first free write cycle: rf_write=1, rf_wrAddr=latched addr, rf_wrData=latched data; host_rsp_data=data; then -> RESP.
  - Addr 0: the write is still issued (the regfile ignores x0); the response is ok.
- Starvation (READ/WRITE):
  - The wait counter increments on each denied cycle and clears on slot or state exit.
  - When it reaches MAX_WAIT, core_stall is registered high for exactly one cycle.
  - The core guarantees the slot is free in that cycle, and the host access completes there.
- CLEAR:
  - core_stall=1 from the cycle after acceptance until the cycle after the last write.
  - Each free write cycle writes 0 to x[clear counter], then increments the counter.
  - If the core writes in that cycle, the counter holds.
  - After x31 is written -> RESP with data=31, err=0.
  - Total = 31 free cycles; x0 is never written.
- RESP:
  - host_rsp_valid=1, with data/err held stable until host_rsp_ready.
  - On valid&ready -> IDLE; the next request can be accepted in the following cycle.
  - host_req_ready=0 in every state except IDLE.
- Requests are strictly one at a time; there is no pipelining of host requests.

Test Plan:
- Reset, then host write op=01 addr=5 data=0xDEADBEEF with core idle -> rf_write=1 with addr 5 one cycle after acceptance; rsp data=0xDEADBEEF, err=0; subsequent host read addr 5 -> rsp data=0xDEADBEEF.
- Host write addr=7 while core_write held high for 5 cycles (core addr 3) -> core writes pass through unchanged; host write issues in cycle 6; no core_stall.
- MAX_WAIT=16, core_rdB_valid held high, host read addr 2 -> core_stall pulses for exactly one cycle after 16 denied cycles; the read completes in that cycle.
- Preload x1..x31 nonzero, host clear-all, core idle -> 31 consecutive writes of 0 to x1..x31; core_stall high throughout; rsp data=31; all reads return 0.
- op=11 -> rsp err=1, no rf_write.
- Hold host_rsp_ready low for 4 cycles -> rsp stable, host_req_ready=0.
- Assert reset during CLEAR at counter=10 -> no further rf_write; host_rsp_valid=0; core_stall=0 the next cycle; x10..x31 retain their old values.
